// File: rtl/wb_data_ram_slave_pkg.sv
// Shared types and widths for the Wishbone data RAM slave.
package wb_data_ram_slave_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Request fields captured when a strobe is accepted in IDLE.
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat;
    logic              err;
  } wb_req_t;

endpackage

// File: rtl/wb_ram_bank.sv
// Four byte-wide RAM lanes with per-lane write enable and registered read.
module wb_ram_bank
  import wb_data_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [SEL_W-1:0]      we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  for (genvar g = 0; g < SEL_W; g++) begin : g_lane
    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rd_q;

    // Byte-lane write and synchronous read; contents are never reset.
    always_ff @(posedge clk_i) begin
      if (we_i[g]) begin
        mem_q[waddr_i] <= wdata_i[g*LANE_W +: LANE_W];
      end
      rd_q <= mem_q[raddr_i];
    end

    assign rdata_o[g*LANE_W +: LANE_W] = rd_q;
  end

endmodule

// File: rtl/wb_data_ram_slave.sv
// Wishbone classic slave with a byte-writable data RAM and programmable wait states.
module wb_data_ram_slave
  import wb_data_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  wb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  wb_req_t               req_q, req_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ack_q, err_q;
  logic [DATA_W-1:0]     dat_q;

  logic                  in_resp;
  logic                  out_of_range;
  logic [SEL_W-1:0]      ram_we;
  logic [DATA_W-1:0]     ram_rdata;

  assign in_resp      = (state_q == ST_RESP);
  assign out_of_range = ((wb_adr_i >> (ADDR_WIDTH + 2)) != 32'd0);

  // Commit the latched write while leaving RESP, unless reset cancels it.
  assign ram_we = (in_resp && req_q.we && !req_q.err && !rst) ? req_q.sel : '0;

  // Next-state, counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          req_d.we  = wb_we_i;
          req_d.sel = wb_sel_i;
          req_d.dat = wb_dat_i;
          req_d.err = out_of_range;
          idx_d     = wb_adr_i[ADDR_WIDTH+1:2];
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latches and registered bus responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      ack_q   <= in_resp && !req_q.err;
      err_q   <= in_resp && req_q.err;
      dat_q   <= (in_resp && !req_q.we && !req_q.err) ? ram_rdata : '0;
    end
  end

  // Read address follows the incoming index in IDLE so a zero-wait read is ready in RESP.
  wb_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (idx_q),
    .wdata_i (req_q.dat),
    .raddr_i (idx_d),
    .rdata_o (ram_rdata)
  );

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Bench for wb_data_ram_slave: three instances (1, 3 and 0 wait states) against a timeline model.
module tb_wb_data_ram_slave;

  localparam int unsigned AW = 10;
  localparam int NI = 3;

  function automatic int unsigned ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [NI];
  logic        stb   [NI];
  logic        we    [NI];
  logic [3:0]  sel   [NI];
  logic [31:0] adr   [NI];
  logic [31:0] dat_w [NI];
  logic [31:0] dat_o [NI];
  logic        ack   [NI];
  logic        err   [NI];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_data_ram_slave #(
      .ADDR_WIDTH  (AW),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (cyc[g]),
      .wb_stb_i (stb[g]),
      .wb_we_i  (we[g]),
      .wb_sel_i (sel[g]),
      .wb_adr_i (adr[g]),
      .wb_dat_i (dat_w[g]),
      .wb_dat_o (dat_o[g]),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, want);
    end
  endtask

  // Timeline model: a request accepted at edge k responds at edge k+W+1, the slave is
  // free again one edge later, dropping cyc before the response cancels it, reset cancels all.
  bit          m_pend [NI];
  int unsigned m_k    [NI];
  int unsigned m_free [NI];
  logic        m_we   [NI];
  logic [3:0]  m_sel  [NI];
  logic [31:0] m_dat  [NI];
  int unsigned m_idx  [NI];
  bit          m_err  [NI];
  logic [31:0] mem_m  [NI][1024];
  logic        exp_ack [NI];
  logic        exp_err [NI];
  logic [31:0] exp_dat [NI];
  int unsigned edge_n = 0;

  initial begin
    for (int d = 0; d < NI; d++) begin
      m_pend[d] = 1'b0; m_free[d] = 0; m_k[d] = 0;
      exp_ack[d] = 1'b0; exp_err[d] = 1'b0; exp_dat[d] = '0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      for (int d = 0; d < NI; d++) begin
        exp_ack[d] = 1'b0;
        exp_err[d] = 1'b0;
        exp_dat[d] = '0;
        if (rst) begin
          m_pend[d] = 1'b0;
          m_free[d] = edge_n + 1;
        end else begin
          if (m_pend[d] && edge_n == m_k[d] + ws_of(d) + 1) begin
            if (m_err[d]) begin
              exp_err[d] = 1'b1;
            end else begin
              exp_ack[d] = 1'b1;
              if (m_we[d]) begin
                for (int b = 0; b < 4; b++) begin
                  if (m_sel[d][b]) mem_m[d][m_idx[d]][8*b +: 8] = m_dat[d][8*b +: 8];
                end
              end else begin
                exp_dat[d] = mem_m[d][m_idx[d]];
              end
            end
            m_pend[d] = 1'b0;
            m_free[d] = edge_n + 1;
          end else if (m_pend[d] && !cyc[d]) begin
            m_pend[d] = 1'b0;
            m_free[d] = edge_n + 1;
          end
          if (!m_pend[d] && edge_n >= m_free[d] && cyc[d] && stb[d]) begin
            m_pend[d] = 1'b1;
            m_k[d]    = edge_n;
            m_we[d]   = we[d];
            m_sel[d]  = sel[d];
            m_dat[d]  = dat_w[d];
            m_idx[d]  = (adr[d] >> 2) % 1024;
            m_err[d]  = (adr[d] >> (AW + 2)) != 0;
          end
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < NI; d++) begin
          chk($sformatf("ack[%0d]@%0d", d, edge_n), 32'(ack[d]), 32'(exp_ack[d]));
          chk($sformatf("err[%0d]@%0d", d, edge_n), 32'(err[d]), 32'(exp_err[d]));
          chk($sformatf("dat[%0d]@%0d", d, edge_n), dat_o[d], exp_dat[d]);
        end
      end
    end
  end

  // One transfer: hold the request until ack/err or a 30-cycle bound; lat counts edges after the sample edge.
  task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic ga,
                      output logic ge, output int lat);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat_w[d] = wd;
    ga = 1'b0; ge = 1'b0; rd = '0; lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        ga = ack[d]; ge = err[d]; rd = dat_o[d]; lat = n - 1;
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ga, ge;
    int          lat, seen, pulses, consec;
    logic        prev;
    logic [31:0] last_rd;

    for (int d = 0; d < NI; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; adr[d] = '0; dat_w[d] = '0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int d = 0; d < NI; d++) begin
      chk($sformatf("reset_ack[%0d]", d), 32'(ack[d]), 32'd0);
      chk($sformatf("reset_err[%0d]", d), 32'(err[d]), 32'd0);
      chk($sformatf("reset_dat[%0d]", d), dat_o[d], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // One wait state: full write, read back, byte lane, empty select.
    xfer(0, 1'b1, 4'b1111, 32'h10, 32'h1234_5678, rd, ga, ge, lat);
    chk("w1_ack", 32'(ga), 32'd1);
    chk("w1_lat", 32'(lat), 32'd2);
    xfer(0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, ga, ge, lat);
    chk("r1_dat", rd, 32'h1234_5678);
    chk("r1_lat", 32'(lat), 32'd2);
    xfer(0, 1'b1, 4'b0100, 32'h10, 32'hAABB_CCDD, rd, ga, ge, lat);
    chk("wlane_ack", 32'(ga), 32'd1);
    xfer(0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, ga, ge, lat);
    chk("rlane_dat", rd, 32'h12BB_5678);
    xfer(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, rd, ga, ge, lat);
    chk("wsel0_ack", 32'(ga), 32'd1);
    xfer(0, 1'b0, 4'b1111, 32'h10, 32'h0, rd, ga, ge, lat);
    chk("rsel0_dat", rd, 32'h12BB_5678);

    // Out of range: error pulse, no ack, zero data, word 0 untouched.
    xfer(0, 1'b1, 4'b1111, 32'h0, 32'h0102_0304, rd, ga, ge, lat);
    xfer(0, 1'b1, 4'b1111, 32'h0000_1000, 32'hFFFF_FFFF, rd, ga, ge, lat);
    chk("oor_err", 32'(ge), 32'd1);
    chk("oor_ack", 32'(ga), 32'd0);
    chk("oor_dat", rd, 32'd0);
    chk("oor_lat", 32'(lat), 32'd2);
    xfer(0, 1'b0, 4'b1111, 32'h0, 32'h0, rd, ga, ge, lat);
    chk("oor_word0", rd, 32'h0102_0304);

    // Three wait states: abort in WAIT leaves memory unchanged.
    xfer(1, 1'b1, 4'b1111, 32'h20, 32'h55AA_55AA, rd, ga, ge, lat);
    chk("w3_lat", 32'(lat), 32'd4);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h20; dat_w[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] || err[1]) seen++;
    end
    chk("abort_noack", 32'(seen), 32'd0);
    xfer(1, 1'b0, 4'b1111, 32'h20, 32'h0, rd, ga, ge, lat);
    chk("abort_dat", rd, 32'h55AA_55AA);

    // Reset during WAIT of a write: discarded, and a request is taken right after reset.
    xfer(1, 1'b1, 4'b1111, 32'h30, 32'h1111_2222, rd, ga, ge, lat);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h30; dat_w[1] = 32'h9999_9999;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", 32'(ack[1]), 32'd0);
    xfer(1, 1'b0, 4'b1111, 32'h30, 32'h0, rd, ga, ge, lat);
    chk("rst_dat", rd, 32'h1111_2222);
    chk("rst_lat", 32'(lat), 32'd4);

    // Zero wait states: held read strobe acks every second cycle.
    xfer(2, 1'b1, 4'b1111, 32'h10, 32'hCAFE_F00D, rd, ga, ge, lat);
    chk("w0_lat", 32'(lat), 32'd1);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; adr[2] = 32'h10;
    pulses = 0; consec = 0; prev = 1'b0; last_rd = '0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2]) begin
        pulses++;
        if (prev) consec++;
        last_rd = dat_o[2];
      end
      prev = ack[2];
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd5);
    chk("held_consec", 32'(consec), 32'd0);
    chk("held_dat", last_rd, 32'hCAFE_F00D);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
